avalon_sram_responder: RTL and testbench
========================================

# avalon_sram_responder

Avalon-style slave responder terminating the slave side of the pass-through Avalon interconnect in the DE10-Nano user logic. It accepts word-addressed single-beat reads and writes from the master side, stores data in an on-chip synchronous RAM, and returns read data in order after a fixed, parameterised latency. It is the default endpoint for the bridge, for bring-up and for bench loopback testing, with optional wait-state insertion to exercise master back-pressure handling.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of slave_address (word address)
- DATA_WIDTH, 32, width of read/write data
- MEM_DEPTH_LOG2, 10, RAM holds 2^MEM_DEPTH_LOG2 words
- READ_LATENCY, 2, cycles from read acceptance to read_data_valid; legal range 1..8
- WAIT_CYCLES, 2, wait states per request when AVS_WAITSTATE_EN is defined; legal range 1..15

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- slave_address  in  ADDR_WIDTH  word address of request
- slave_ready  out  1  request accepted on a rising edge where ready and a req are both high
- slave_write_data  in  DATA_WIDTH  write data
- slave_write_req  in  1  write request, held until accepted
- slave_read_req  in  1  read request, held until accepted
- slave_read_data  out  DATA_WIDTH  read data, qualified by valid
- slave_read_data_valid  out  1  one-cycle pulse per accepted read

## Operation
- Acceptance: accept = slave_ready & (slave_write_req | slave_read_req), sampled at rising clk.
- Addressing: only slave_address[MEM_DEPTH_LOG2-1:0] used; upper bits ignored, so addresses alias modulo 2^MEM_DEPTH_LOG2.
- Write: on accepted write, RAM[addr] <= slave_write_data at that edge. No response generated.
- Read: on accepted read, RAM[addr] is read at that edge and enters a READ_LATENCY-deep valid/data pipeline. No back-pressure on the response path; the pipeline accepts one read per cycle.
- Ordering: responses return strictly in acceptance order; a read accepted the cycle after a write to the same address returns the new data.
- Both reqs high in the same cycle: illegal master behaviour; the block performs the write only, generates no read response, and sets no error flag.
- RAM contents are not reset; reads of never-written words return undefined data.
- Without AVS_WAITSTATE_EN: slave_ready is a register, 0 in reset, 1 from the first clk edge after rst_n deasserts, then constant.
- With AVS_WAITSTATE_EN: two-state FSM, IDLE/WAIT.
  - IDLE: ready=0. A request seen (either req high) -> WAIT, counter loaded with WAIT_CYCLES-1.
  - WAIT: ready=0 while counter>0, decrement each cycle; when counter==0, ready=1 for exactly that cycle, request accepted, -> IDLE.
  - A req dropped in WAIT (protocol violation) -> IDLE at next edge; no access performed.
  - Back-to-back requests therefore accept at most once every WAIT_CYCLES+1 cycles.

## Timing
- Reset values: slave_ready=0, slave_read_data_valid=0, slave_read_data=0, pipeline valids cleared, FSM=IDLE, counter=0.
- Read latency: read accepted at edge N -> slave_read_data_valid=1 and data stable in the cycle following edge N+READ_LATENCY-1 (READ_LATENCY=1: valid in the cycle directly after acceptance).
- slave_read_data holds its last returned value while valid is low.
- Write latency: data visible to any read accepted at edge N+1 or later.
- Reset asserted mid-operation: in-flight read responses are discarded (no valid pulse after reset); pending writes not yet accepted are lost; RAM keeps its contents.
- Wait-state mode: request first high in cycle c -> ready high in cycle c+WAIT_CYCLES.

## Configuration
- AVS_WAITSTATE_EN: defined -> IDLE/WAIT FSM and counter compiled in; every request incurs WAIT_CYCLES wait states. Undefined -> FSM and counter omitted; ready always 1 after reset, one access per cycle.

## Test plan
- Reset release, macro undefined -> ready 0 during reset, 1 one edge after rst_n rises; valid stays 0.
- Write 0xDEADBEEF to addr 5, read addr 5 next cycle, READ_LATENCY=2 -> valid pulse 2 cycles after read acceptance with data 0xDEADBEEF.
- Streaming reads of addr 0..15 back-to-back after filling with data=addr*3 -> 16 consecutive valid cycles, data 0,3,...,45 in order.
- Alias: MEM_DEPTH_LOG2=10, write 0x11 to addr 0x405, read addr 0x005 -> returns 0x11.
- AVS_WAITSTATE_EN, WAIT_CYCLES=2, read held from cycle 0 -> ready high only in cycle 2, one valid pulse; next back-to-back request accepted in cycle 5.
- Reset asserted one cycle after a read acceptance with READ_LATENCY=3 -> no valid pulse after reset; prior written data still readable afterwards.

Source files
------------

// File: rtl/avalon_sram_if.sv
// Avalon-style single-beat request/response bundle between the bridge master
// and the SRAM responder.
interface avalon_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] slave_address;
  logic [DATA_WIDTH-1:0] slave_write_data;
  logic                  slave_write_req;
  logic                  slave_read_req;
  logic                  slave_ready;
  logic [DATA_WIDTH-1:0] slave_read_data;
  logic                  slave_read_data_valid;

  modport master (
    output slave_address, slave_write_data, slave_write_req, slave_read_req,
    input  slave_ready, slave_read_data, slave_read_data_valid
  );

  modport slave (
    input  slave_address, slave_write_data, slave_write_req, slave_read_req,
    output slave_ready, slave_read_data, slave_read_data_valid
  );
endinterface

// File: rtl/avalon_sram_responder.sv
// Avalon-style slave terminating the bridge in an on-chip RAM with a fixed read latency.
// Define AVS_WAITSTATE_EN to insert WAIT_CYCLES wait states per request (IDLE/WAIT FSM).
module avalon_sram_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int READ_LATENCY   = 2,
  parameter int WAIT_CYCLES    = 2
) (
  input logic        clk,
  input logic        rst_n,
  avalon_sram_if.slave avs
);
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                      ready_w;
  logic                      req_any;
  logic                      accept;
  logic                      wr_en;
  logic                      rd_en;
  logic [MEM_DEPTH_LOG2-1:0] idx;
  logic                      unused_addr_bits;

  logic [READ_LATENCY-1:0]                 pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;

  assign req_any = avs.slave_write_req | avs.slave_read_req;
  assign accept  = ready_w & req_any;
  // Both reqs high is a master error: only the write is honoured.
  assign wr_en   = accept & avs.slave_write_req;
  assign rd_en   = accept & avs.slave_read_req & ~avs.slave_write_req;
  assign idx     = avs.slave_address[MEM_DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^avs.slave_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2];

  // RAM is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= avs.slave_write_data;
    end
  end

  // Data stages only advance behind a valid, so the last stage holds the
  // most recently returned word while valid is low.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_data_d    = pipe_data_q;
    pipe_vld_d[0]  = rd_en;
    if (rd_en) begin
      pipe_data_d[0] = mem[idx];
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      if (pipe_vld_q[k-1]) begin
        pipe_data_d[k] = pipe_data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q  <= '0;
      pipe_data_q <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  assign avs.slave_read_data       = pipe_data_q[READ_LATENCY-1];
  assign avs.slave_read_data_valid = pipe_vld_q[READ_LATENCY-1];
  assign avs.slave_ready           = ready_w;

`ifdef AVS_WAITSTATE_EN
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        ready_w = (cnt_q == 4'd0);
        if (!req_any || cnt_q == 4'd0) begin
          // A dropped request aborts the wait without touching the RAM.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic ready_q, ready_d;

  assign ready_d = 1'b1;
  assign ready_w = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end
`endif
endmodule

// File: tb/tb_avalon_sram_responder.sv
// Self-checking bench for avalon_sram_responder: directed cases plus randomized
// traffic checked against an associative-array memory model and expected-response queue.
module tb_avalon_sram_responder;
  localparam int AW = 32, DW = 32, MDL = 10, RL = 2, WC = 2;
  localparam int DEPTH = 1 << MDL;
`ifdef AVS_WAITSTATE_EN
  localparam int EXP_WAIT = WC;
  localparam bit EXP_READY_IDLE = 1'b0;
`else
  localparam int EXP_WAIT = 0;
  localparam bit EXP_READY_IDLE = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_sram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  avalon_sram_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(MDL),
    .READ_LATENCY(RL), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .avs(bus)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            known;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_valid = 0;
  exp_t          expq[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every valid must match the head of the expected queue in
  // both cycle and data; data must hold while valid is low.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("valid_in_reset", 64'(bus.slave_read_data_valid), 64'(0));
      chk("ready_in_reset", 64'(bus.slave_ready), 64'(0));
      chk("data_in_reset", 64'(bus.slave_read_data), 64'(0));
      last_data = '0;
    end else if (bus.slave_read_data_valid) begin
      n_valid++;
      if (expq.size() == 0) begin
        chk("spurious_valid", 64'(1), 64'(0));
      end else begin
        e = expq.pop_front();
        chk("valid_cycle", 64'(cyc), 64'(e.due));
        if (e.known) chk("read_data", 64'(bus.slave_read_data), 64'(e.data));
      end
      last_data = bus.slave_read_data;
    end else begin
      chk("data_hold", 64'(bus.slave_read_data), 64'(last_data));
      if (expq.size() > 0 && expq[0].due <= cyc) begin
        chk("missing_valid", 64'(0), 64'(1));
        void'(expq.pop_front());
      end
    end
  end

  // Starts and ends on a falling edge; holds the request until accepted.
  task automatic issue(input bit wr, input bit rd, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    bit   done = 1'b0;
    int   waited = 0;
    int   key;
    exp_t e;
    bus.slave_address    = addr;
    bus.slave_write_data = wdata;
    bus.slave_write_req  = wr;
    bus.slave_read_req   = rd;
    key = int'(addr % DEPTH);
    while (!done && waited < 64) begin
      if (bus.slave_ready) begin
        done = 1'b1;
        chk("wait_states", 64'(waited), 64'(EXP_WAIT));
        if (wr) begin
          ref_mem[key] = wdata;
        end else if (rd) begin
          e.due   = cyc + RL;
          e.known = ref_mem.exists(key);
          e.data  = e.known ? ref_mem[key] : '0;
          expq.push_back(e);
        end
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 64'(done), 64'(1));
    bus.slave_write_req = 1'b0;
    bus.slave_read_req  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(expq.size()), 64'(0));
  endtask

  initial begin
    int n0;
    int op;
    logic [AW-1:0] a;
    bus.slave_address    = '0;
    bus.slave_write_data = '0;
    bus.slave_write_req  = 1'b0;
    bus.slave_read_req   = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("ready_before_edge", 64'(bus.slave_ready), 64'(0));
    @(negedge clk);
    chk("ready_after_release", 64'(bus.slave_ready), 64'(EXP_READY_IDLE));
    chk("valid_after_release", 64'(bus.slave_read_data_valid), 64'(0));

    issue(1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 32'd5, '0);
    repeat (RL - 1) @(negedge clk);
    chk("deadbeef_valid", 64'(bus.slave_read_data_valid), 64'(1));
    chk("deadbeef_data", 64'(bus.slave_read_data), 64'(32'hDEADBEEF));
    drain();

    issue(1'b1, 1'b0, 32'h405, 32'h11);
    issue(1'b0, 1'b1, 32'h005, '0);
    drain();
    chk("alias_data", 64'(last_data), 64'(32'h11));

    for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, AW'(i), DW'(i * 3));
    n0 = n_valid;
    for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, AW'(i), '0);
    drain();
    chk("stream_count", 64'(n_valid - n0), 64'(16));
    chk("stream_last", 64'(last_data), 64'(45));

    n0 = n_valid;
    issue(1'b1, 1'b1, 32'd7, 32'hCAFE0007);
    repeat (RL + 2) @(negedge clk);
    chk("both_req_no_resp", 64'(n_valid - n0), 64'(0));
    issue(1'b0, 1'b1, 32'd7, '0);
    drain();
    chk("both_req_wrote", 64'(last_data), 64'(32'hCAFE0007));

    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 9));
      a  = ($urandom & 32'hFFFF_FC00) | AW'($urandom_range(0, 31));
      if (op < 4)      issue(1'b1, 1'b0, a, $urandom);
      else if (op < 9) issue(1'b0, 1'b1, a, '0);
      else             issue(1'b1, 1'b1, a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    issue(1'b1, 1'b0, 32'd9, 32'h1234_5678);
    issue(1'b0, 1'b1, 32'd9, '0);
    #2 rst_n = 1'b0;
    expq.delete();
    n0 = n_valid;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (RL + 2) @(negedge clk);
    chk("no_valid_after_reset", 64'(n_valid - n0), 64'(0));
    issue(1'b0, 1'b1, 32'd9, '0);
    drain();
    chk("ram_kept_over_reset", 64'(last_data), 64'(32'h1234_5678));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
